// File: rtl/qnt_pkg.sv
// Shared quantization constants and the serializer FSM state type.
// PLACE_BIT_DEF tracks the quantizer's START_QUANTIZE_BIT so a frame round-trips.
package qnt_pkg;
  localparam int WORD_BITS_DEF      = 32;
  localparam int ACT_BITS_DEF       = 8;
  localparam int START_QUANTIZE_BIT = 11;
  localparam int PLACE_BIT_DEF      = START_QUANTIZE_BIT;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;
endpackage

// File: rtl/serial_shift_reg.sv
// WORD_BITS load/shift register emitting its contents LSB first.
// Load has priority over shift so a new word can replace the last bit in one edge.
module serial_shift_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] load_data_i,
  output logic         ser_o
);
  logic [W-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= load_data_i;
    end else if (shift_i) begin
      sr_q <= {1'b0, sr_q[W-1:1]};
    end
  end

  assign ser_o = sr_q[0];
endmodule

// File: rtl/activation_serializer.sv
// Re-expands an activation byte into a LSB-first serial word with the byte at PLACE_BIT.
// valid/ready: a byte moves when in_valid && in_ready at a posedge; in_ready is registered and means the hold register is empty.
module activation_serializer
  import qnt_pkg::*;
#(
  parameter int WORD_BITS = WORD_BITS_DEF,
  parameter int ACT_BITS  = ACT_BITS_DEF,
  parameter int PLACE_BIT = PLACE_BIT_DEF,
  parameter int SIGNED    = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [ACT_BITS-1:0] in_data,
  output logic                in_ready,
  output logic                data_out,
  output logic                frame_start,
  output logic                out_valid,
  output logic                dbg_state_o
);
  localparam int             CW   = $clog2(WORD_BITS);
  localparam logic [CW-1:0]  LAST = CW'(WORD_BITS - 1);

  ser_state_e            state_q;
  logic [CW-1:0]         cnt_q;
  logic [ACT_BITS-1:0]   hold_q;
  logic                  hold_full_q;
  logic                  hold_full_d;
  logic                  accept;
  logic                  transfer;
  logic                  fill;
  logic [WORD_BITS-1:0]  ext_word;
  logic [WORD_BITS-1:0]  load_word;
  logic                  sr_bit;

  assign accept   = in_valid && in_ready;
  // The hold empties into the shifter whenever the shifter has nothing left to send.
  assign transfer = hold_full_q && ((state_q == IDLE) || (cnt_q == LAST));

  always_comb begin
    hold_full_d = hold_full_q;
    if (transfer) hold_full_d = 1'b0;
    if (accept)   hold_full_d = 1'b1;
  end

  always_comb begin
    fill      = (SIGNED != 0) && hold_q[ACT_BITS-1];
    ext_word  = {{(WORD_BITS-ACT_BITS){fill}}, hold_q};
    load_word = ext_word << PLACE_BIT;
  end

  serial_shift_reg #(.W(WORD_BITS)) u_shift (
    .clk         (clk),
    .rst_n       (reset),
    .load_i      (transfer),
    .shift_i     (state_q == SHIFT),
    .load_data_i (load_word),
    .ser_o       (sr_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      in_ready    <= 1'b0;
      data_out    <= 1'b0;
      frame_start <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      in_ready    <= !hold_full_d;
      if (accept) hold_q <= in_data;
      case (state_q)
        IDLE: begin
          data_out    <= 1'b0;
          frame_start <= 1'b0;
          out_valid   <= 1'b0;
          if (transfer) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          data_out    <= sr_bit;
          frame_start <= (cnt_q == '0);
          out_valid   <= 1'b1;
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            if (!hold_full_q) state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dbg_state_o = (state_q == SHIFT);
endmodule

// File: tb/tb_activation_serializer.sv
// Bench for activation_serializer: unsigned and signed instances share one stimulus stream
// and are compared every cycle against a queue-of-bits reference model.
module tb_activation_serializer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready_u, data_out_u, frame_start_u, out_valid_u, dbg_u;
  logic in_ready_s, data_out_s, frame_start_s, out_valid_s, dbg_s;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  activation_serializer #(.WORD_BITS(32), .ACT_BITS(8), .PLACE_BIT(11), .SIGNED(0)) dut_u (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_u),
    .data_out(data_out_u), .frame_start(frame_start_u), .out_valid(out_valid_u), .dbg_state_o(dbg_u));

  activation_serializer #(.WORD_BITS(32), .ACT_BITS(8), .PLACE_BIT(11), .SIGNED(1)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_s),
    .data_out(data_out_s), .frame_start(frame_start_s), .out_valid(out_valid_s), .dbg_state_o(dbg_s));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame word as plain arithmetic: (signed or unsigned byte value) * 2^11, modulo 2^32.
  function automatic logic [31:0] mk_word(input logic [7:0] b, input bit sgn);
    longint v;
    v = (sgn && b >= 8'd128) ? longint'(b) - 256 : longint'(b);
    v = v * 2048;
    return v[31:0];
  endfunction

  // Reference model: a pending hold byte and a queue of bits still to be emitted ({start, bit}).
  logic [7:0] m_hold = 8'h00;
  bit         m_full = 1'b0;
  bit         m_ready = 1'b0;
  logic [1:0] q_u[$];
  logic [1:0] q_s[$];
  logic       e_valid = 1'b0, e_du = 1'b0, e_ds = 1'b0, e_fs = 1'b0;

  always @(posedge clk or negedge reset) begin : model
    bit acc;
    logic [1:0] eu, es;
    logic [31:0] wu, ws;
    if (!reset) begin
      m_full = 1'b0; m_ready = 1'b0; q_u.delete(); q_s.delete();
      e_valid = 1'b0; e_du = 1'b0; e_ds = 1'b0; e_fs = 1'b0;
    end else begin
      acc = in_valid && m_ready;
      if (q_u.size() > 0) begin
        eu = q_u.pop_front(); es = q_s.pop_front();
        e_valid = 1'b1; e_du = eu[0]; e_ds = es[0]; e_fs = eu[1];
      end else begin
        e_valid = 1'b0; e_du = 1'b0; e_ds = 1'b0; e_fs = 1'b0;
      end
      if (m_full && q_u.size() == 0) begin
        wu = mk_word(m_hold, 1'b0);
        ws = mk_word(m_hold, 1'b1);
        for (int i = 0; i < 32; i++) begin
          q_u.push_back({i == 0, wu[i]});
          q_s.push_back({i == 0, ws[i]});
        end
        m_full = 1'b0;
      end
      if (acc) begin
        m_hold = in_data;
        m_full = 1'b1;
      end
      m_ready = !m_full;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready_u", in_ready_u, m_ready);
      check("in_ready_s", in_ready_s, m_ready);
      check("out_valid_u", out_valid_u, e_valid);
      check("out_valid_s", out_valid_s, e_valid);
      check("frame_start_u", frame_start_u, e_fs);
      check("frame_start_s", frame_start_s, e_fs);
      check("data_out_u", data_out_u, e_du);
      check("data_out_s", data_out_s, e_ds);
    end
  end

  // Whole-frame capture and longest out_valid run, rebuilt from the serial pins.
  logic [31:0] capq_u[$];
  logic [31:0] capq_s[$];
  logic [31:0] cw_u, cw_s;
  int idx_u = -1, idx_s = -1;
  int run = 0, max_run = 0;

  always @(negedge clk) begin
    if (!reset) begin
      idx_u = -1; idx_s = -1; run = 0;
    end else begin
      run = out_valid_u ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (out_valid_u) begin
        if (frame_start_u) begin idx_u = 0; cw_u = '0; end
        if (idx_u >= 0) begin
          cw_u[idx_u] = data_out_u; idx_u++;
          if (idx_u == 32) begin capq_u.push_back(cw_u); idx_u = -1; end
        end
      end
      if (out_valid_s) begin
        if (frame_start_s) begin idx_s = 0; cw_s = '0; end
        if (idx_s >= 0) begin
          cw_s[idx_s] = data_out_s; idx_s++;
          if (idx_s == 32) begin capq_s.push_back(cw_s); idx_s = -1; end
        end
      end
    end
  end

  logic [7:0] exp_q[$];

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int n = 0; n < 300 && !done; n++) begin
      if (m_ready) done = 1'b1;
      @(posedge clk);
      if (!done) @(negedge clk);
    end
    if (done) exp_q.push_back(b);
    else check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic stop_valid();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_frames(output logic [31:0] wu, output logic [31:0] ws);
    for (int n = 0; n < 200 && (capq_u.size() == 0 || capq_s.size() == 0); n++) @(negedge clk);
    if (capq_u.size() == 0 || capq_s.size() == 0) begin
      check("frame_timeout", 32'd0, 32'd1);
      wu = '0; ws = '0;
    end else begin
      wu = capq_u.pop_front();
      ws = capq_s.pop_front();
    end
  endtask

  task automatic run_one(input logic [7:0] b, input logic [31:0] exp_u, input logic [31:0] exp_s);
    logic [31:0] wu, ws;
    send_byte(b);
    stop_valid();
    get_frames(wu, ws);
    check("word_u", wu, exp_u);
    check("word_s", ws, exp_s);
    check("roundtrip_u", {24'd0, wu[18:11]}, {24'd0, b});
  endtask

  initial begin
    logic [31:0] wu, ws;
    logic [7:0] b;
    int cnt_v;
    #1 reset = 1'b0;
    chk_en = 1'b1;
    #1 check("reset_valid", out_valid_u, 1'b0);
    check("reset_ready", in_ready_u, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check("ready_after_release", in_ready_u, 1'b1);
    repeat (5) @(negedge clk);

    check("model_w05", mk_word(8'h05, 1'b0), 32'h0000_2800);
    check("model_w80s", mk_word(8'h80, 1'b1), 32'hFFFC_0000);

    run_one(8'h05, 32'h0000_2800, 32'h0000_2800);
    run_one(8'hFF, 32'h0007_F800, 32'hFFFF_F800);
    run_one(8'h00, 32'h0000_0000, 32'h0000_0000);
    run_one(8'h01, 32'h0000_0800, 32'h0000_0800);
    run_one(8'h80, 32'h0004_0000, 32'hFFFC_0000);
    run_one(8'h7F, 32'h0003_F800, 32'h0003_F800);
    repeat (10) @(negedge clk);

    max_run = 0;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    stop_valid();
    repeat (120) @(negedge clk);
    check("stream_run", max_run, 96);
    get_frames(wu, ws); check("stream_w0", wu, 32'h0000_0800);
    get_frames(wu, ws); check("stream_w1", wu, 32'h0000_1000);
    get_frames(wu, ws); check("stream_w2", wu, 32'h0000_1800);

    send_byte(8'h11);
    send_byte(8'h22);
    stop_valid();
    for (int n = 0; n < 200 && !(q_u.size() == 11 && m_full); n++) @(negedge clk);
    check("reached_bit20", (q_u.size() == 11 && m_full), 1'b1);
    #2 reset = 1'b0;
    #1 check("async_valid_u", out_valid_u, 1'b0);
    check("async_valid_s", out_valid_s, 1'b0);
    check("async_data_u", data_out_u, 1'b0);
    check("async_start_u", frame_start_u, 1'b0);
    check("async_ready_u", in_ready_u, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cnt_v = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid_u || out_valid_s) cnt_v++;
    end
    check("post_reset_silent", cnt_v, 0);
    capq_u.delete(); capq_s.delete();
    run_one(8'h33, 32'h0001_9800, 32'h0001_9800);
    repeat (5) @(negedge clk);

    capq_u.delete(); capq_s.delete(); exp_q.delete();
    for (int k = 0; k < 120; k++) begin
      b = 8'($urandom_range(0, 255));
      send_byte(b);
      if ($urandom_range(0, 2) == 0) begin
        stop_valid();
        repeat ($urandom_range(0, 40)) @(negedge clk);
      end
    end
    stop_valid();
    repeat (100) @(negedge clk);
    check("rand_count_u", capq_u.size(), exp_q.size());
    check("rand_count_s", capq_s.size(), exp_q.size());
    while (exp_q.size() > 0 && capq_u.size() > 0 && capq_s.size() > 0) begin
      b = exp_q.pop_front();
      check("rand_word_u", capq_u.pop_front(), mk_word(b, 1'b0));
      check("rand_word_s", capq_s.pop_front(), mk_word(b, 1'b1));
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
